float_sub_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor computing y = a - b. It complements the combinational float adder: b's sign is inverted, then the operands go through an iterative align / add / normalize datapath that shifts one bit per cycle. It uses a start/done/busy handshake and sits beside the combinational adder in the float arithmetic library.

---
 rtl/float_sub_seq.sv | 166 ++++++++++++++++
 tb/tb_float_sub_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (y = a - b) built on an
// iterative align / add / normalize datapath that shifts one bit per cycle.
module float_sub_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

  state_t      state_q, state_d;
  logic        sx_q, sx_d;
  logic        eff_sub_q, eff_sub_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  diff_q, diff_d;
  logic [23:0] mx_q, mx_d;
  logic [23:0] my_q, my_d;
  logic [24:0] m_q, m_d;
  logic [31:0] y_q, y_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // Unpacked operands; b's sign is inverted so the datapath performs an add.
  logic        sign_b;
  logic [7:0]  ea, eb, exp_p1;
  logic [23:0] ma, mb;
  logic        a_larger;

  assign sign_b   = ~b[31];
  assign ea       = a[30:23];
  assign eb       = b[30:23];
  assign ma       = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
  assign mb       = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
  assign a_larger = ({ea, ma} >= {eb, mb});
  assign exp_p1   = exp_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    sx_d      = sx_q;
    eff_sub_d = eff_sub_q;
    exp_d     = exp_q;
    diff_d    = diff_q;
    mx_d      = mx_q;
    my_d      = my_q;
    m_d       = m_q;
    y_d       = y_q;
    done_d    = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (a_larger) begin
            sx_d   = a[31];
            exp_d  = ea;
            mx_d   = ma;
            my_d   = mb;
            diff_d = ea - eb;
          end else begin
            sx_d   = sign_b;
            exp_d  = eb;
            mx_d   = mb;
            my_d   = ma;
            diff_d = eb - ea;
          end
          eff_sub_d = a[31] ^ sign_b;
          busy_d    = 1'b1;
          state_d   = ALIGN;
        end
      end

      ALIGN: begin
        if (diff_q > 8'd24) begin
          my_d    = 24'd0;
          state_d = ADD;
        end else if (diff_q == 8'd0 || my_q == 24'd0) begin
          state_d = ADD;
        end else begin
          my_d   = my_q >> 1;
          diff_d = diff_q - 8'd1;
        end
      end

      ADD: begin
        m_d     = eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                            : ({1'b0, mx_q} + {1'b0, my_q});
        state_d = NORM;
      end

      NORM: begin
        // Every finishing branch loads y, pulses done and returns to IDLE.
        if (m_q == 25'd0) begin
          y_d     = 32'h0000_0000;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (m_q[24]) begin
          m_d   = m_q >> 1;
          exp_d = exp_p1;
          if (exp_p1 == 8'hFF) begin
            y_d     = {sx_q, 8'hFF, 23'd0};
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (m_q[23]) begin
          y_d     = {sx_q, exp_q, m_q[22:0]};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (exp_q == 8'd1) begin
          y_d     = 32'h0000_0000;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          m_d   = m_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      sx_q      <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= 8'd0;
      diff_q    <= 8'd0;
      mx_q      <= 24'd0;
      my_q      <= 24'd0;
      m_q       <= 25'd0;
      y_q       <= 32'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sx_q      <= sx_d;
      eff_sub_q <= eff_sub_d;
      exp_q     <= exp_d;
      diff_q    <= diff_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      m_q       <= m_d;
      y_q       <= y_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign y    = y_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_float_sub_seq.sv
// Randomized self-checking bench for float_sub_seq: a behavioural reference
// model predicts result and latency, and a compare process checks every cycle.
module tb_float_sub_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
  logic        done;
  logic        busy;

  int vectors;
  int miscompares;

  float_sub_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .y     (y),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: value semantics of the subtractor plus its cycle cost.
  function automatic void ref_sub(input logic [31:0] a_in, input logic [31:0] b_in,
                                  output logic [31:0] y_out, output int lat);
    logic        sa, sb, sx, sy, fin;
    int          ea, eb, ex, ey, d, e, align, cnt;
    logic [23:0] ma, mb;
    logic [24:0] mx, my, m;
    sa = a_in[31];
    sb = ~b_in[31];
    ea = int'(a_in[30:23]);
    eb = int'(b_in[30:23]);
    ma = (ea == 0) ? 24'd0 : {1'b1, a_in[22:0]};
    mb = (eb == 0) ? 24'd0 : {1'b1, b_in[22:0]};
    if (ea > eb || (ea == eb && ma >= mb)) begin
      sx = sa; sy = sb; ex = ea; ey = eb; mx = {1'b0, ma}; my = {1'b0, mb};
    end else begin
      sx = sb; sy = sa; ex = eb; ey = ea; mx = {1'b0, mb}; my = {1'b0, ma};
    end
    d = ex - ey;
    if (d > 24) begin
      my = 25'd0;
      align = 1;
    end else if (d == 0 || my == 25'd0) begin
      align = 1;
    end else begin
      my = my >> d;
      align = d + 1;
    end
    m = (sx == sy) ? (mx + my) : (mx - my);
    e = ex;
    cnt = 0;
    fin = 1'b0;
    y_out = 32'd0;
    for (int it = 0; it < 64 && !fin; it++) begin
      cnt++;
      if (m == 25'd0) begin
        y_out = 32'd0; fin = 1'b1;
      end else if (m[24]) begin
        m = m >> 1;
        e = e + 1;
        if (e == 255) begin
          y_out = {sx, 8'hFF, 23'd0}; fin = 1'b1;
        end
      end else if (m[23]) begin
        y_out = {sx, 8'(e), m[22:0]}; fin = 1'b1;
      end else if (e == 1) begin
        y_out = 32'd0; fin = 1'b1;
      end else begin
        m = m << 1;
        e = e - 1;
      end
    end
    lat = align + 1 + cnt;
  endfunction

  // Compare process: advances the expected interface state every edge, then
  // checks the DUT just after the edge.
  initial begin
    logic        s_reset, s_start, exp_busy, exp_done, y_known, loose;
    logic [31:0] s_a, s_b, exp_y, pend_y;
    int          rem, loose_cnt;
    exp_busy = 1'b0; exp_done = 1'b0; exp_y = 32'd0; pend_y = 32'd0;
    y_known = 1'b0; loose = 1'b0; rem = 0; loose_cnt = 0;
    forever begin
      @(posedge clk);
      s_reset = reset; s_start = start; s_a = a; s_b = b;
      exp_done = 1'b0;
      if (!s_reset) begin
        exp_busy = 1'b0; exp_y = 32'd0; y_known = 1'b1; loose = 1'b0;
      end else if (exp_busy) begin
        if (loose) begin
          loose_cnt++;
        end else begin
          rem--;
          if (rem == 0) begin
            exp_busy = 1'b0; exp_done = 1'b1; exp_y = pend_y; y_known = 1'b1;
          end
        end
      end else if (s_start) begin
        exp_busy = 1'b1;
        if (s_a[30:23] == 8'hFF || s_b[30:23] == 8'hFF) begin
          loose = 1'b1; loose_cnt = 0;
        end else begin
          ref_sub(s_a, s_b, pend_y, rem);
        end
      end
      #1;
      if (loose) begin
        if (done) begin
          check_output("special_latency_bound", 32'(loose_cnt <= 52), 32'd1);
          check_output("special_busy_at_done", 32'(busy), 32'd0);
          exp_busy = 1'b0; loose = 1'b0; y_known = 1'b0;
        end else if (loose_cnt > 52) begin
          check_output("special_done_timeout", 32'(loose_cnt), 32'd52);
          exp_busy = 1'b0; loose = 1'b0; y_known = 1'b0;
        end else begin
          check_output("special_busy", 32'(busy), 32'd1);
        end
      end else begin
        check_output("busy", 32'(busy), 32'(exp_busy));
        check_output("done", 32'(done), 32'(exp_done));
        if (y_known) check_output("y", y, exp_y);
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] op_a, input logic [31:0] op_b);
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 60; n++) begin
      if (done) break;
      @(negedge clk);
    end
    if (n >= 60) check_output("done_wait_timeout", 32'(n), 32'd59);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    int          lat;
  } pin_t;

  pin_t pins[8];

  initial begin
    logic [31:0] my_y, ra, rb;
    int          my_lat, ea, eb, sel;
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;

    pins[0] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 3};
    pins[1] = '{32'h40400000, 32'h3F800000, 32'h40000000, 4};
    pins[2] = '{32'h3F800000, 32'hBF800000, 32'h40000000, 4};
    pins[3] = '{32'h3F000000, 32'h3F800000, 32'hBF000000, 5};
    pins[4] = '{32'h3FC00000, 32'h3FA00000, 32'h3E800000, 5};
    pins[5] = '{32'h3F800000, 32'h30800000, 32'h3F800000, 3};
    pins[6] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3};
    pins[7] = '{32'h00C00000, 32'h00800000, 32'h00000000, 3};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (pins[i]) begin
      ref_sub(pins[i].a, pins[i].b, my_y, my_lat);
      check_output("model_pin_y", my_y, pins[i].y);
      check_output("model_pin_latency", 32'(my_lat), 32'(pins[i].lat));
    end

    $display("[TB] directed vectors, back-to-back");
    foreach (pins[i]) begin
      apply_stimulus(pins[i].a, pins[i].b);
      wait_done();
    end

    $display("[TB] start while busy is ignored");
    apply_stimulus(32'h40400000, 32'h3F800000);
    a = 32'h3F800000;
    b = 32'hBF800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    $display("[TB] reset in the middle of alignment");
    apply_stimulus(32'h3F800000, 32'h3C000000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);

    $display("[TB] unsupported Inf operand still finishes");
    apply_stimulus(32'h7F800000, 32'h3F800000);
    wait_done();
    @(negedge clk);
    apply_stimulus(32'h40400000, 32'h3F800000);
    wait_done();

    $display("[TB] randomized vectors");
    for (int k = 0; k < 300; k++) begin
      ra = $urandom;
      rb = $urandom;
      ea = int'($urandom_range(0, 254));
      sel = int'($urandom_range(0, 7));
      if (sel == 0) eb = 0;
      else if (sel < 3) eb = int'($urandom_range(0, 254));
      else begin
        eb = ea + int'($urandom_range(0, 60)) - 30;
        if (eb < 0) eb = 0;
        if (eb > 254) eb = 254;
      end
      if (sel == 7) begin
        ea = int'($urandom_range(1, 3));
        eb = ea;
      end
      if (sel == 5) begin
        ea = 254;
        eb = int'($urandom_range(250, 254));
      end
      ra[30:23] = 8'(ea);
      rb[30:23] = 8'(eb);
      if (sel == 6) rb = ra;
      apply_stimulus(ra, rb);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
